// File: rtl/dly_pkg.sv
// rtl/dly_pkg.sv - shared timing constants and sizing helpers for the delay bank
package dly_pkg;

  localparam int TICK_NS = 20;

  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

  // Floor to whole ticks, but never below one tick so a short delay still fires.
  function automatic int ns_to_ticks(input int ns);
    int t;
    t = ns / TICK_NS;
    return (t < 1) ? 1 : t;
  endfunction

endpackage

// File: rtl/dly_bank_if.sv
// rtl/dly_bank_if.sv - trigger/control inputs and pulse/busy outputs of the delay bank
interface dly_bank_if #(
  parameter int NCH = 4,
  parameter int W   = 8
);
  logic [NCH-1:0]   in;
  logic [NCH-1:0]   clr;
  logic [NCH-1:0]   rep;
  logic [NCH*W-1:0] dly;
  logic [NCH-1:0]   p;
  logic [NCH-1:0]   l;
  logic             any;

  modport master (output in, clr, rep, dly, input p, l, any);
  modport slave  (input in, clr, rep, dly, output p, l, any);
endinterface

// File: rtl/dly_chan.sv
// rtl/dly_chan.sv - one delay channel: counter, latched target, repeat flag, busy level
module dly_chan
  import dly_pkg::*;
#(
  parameter int W      = 8,
  parameter int RETRIG = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in,
  input  logic         clr,
  input  logic         rep,
  input  logic [W-1:0] dly,
  output logic         p,
  output logic         l
);

  logic [W-1:0] r;
  logic [W-1:0] t;
  logic         m;
  logic         accept;

  assign p      = l & (r == t) & ~clr;
  // The expiry cycle always re-arms, so RETRIG=0 only blocks mid-count triggers.
  assign accept = in & ~clr & (~l | p | (RETRIG != 0));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r <= '0;
      t <= '0;
      m <= 1'b0;
      l <= 1'b0;
    end else if (clr) begin
      r <= '0;
      m <= 1'b0;
      l <= 1'b0;
    end else if (accept) begin
      r <= W'(1);
      t <= (dly == '0) ? W'(1) : dly;
      m <= rep;
      l <= 1'b1;
    end else if (p) begin
      if (m) begin
        r <= W'(1);
      end else begin
        r <= '0;
        l <= 1'b0;
      end
    end else if (l) begin
      r <= r + W'(1);
    end
  end

endmodule

// File: rtl/dly_bank.sv
// rtl/dly_bank.sv - NCH independent runtime-programmable delay channels
module dly_bank
  import dly_pkg::*;
#(
  parameter int NCH    = 4,
  parameter int W      = 8,
  parameter int RETRIG = 1
) (
  input logic     clk,
  input logic     reset,
  dly_bank_if.slave bus
);

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    dly_chan #(
      .W      (W),
      .RETRIG (RETRIG)
    ) u_chan (
      .clk   (clk),
      .reset (reset),
      .in    (bus.in[i]),
      .clr   (bus.clr[i]),
      .rep   (bus.rep[i]),
      .dly   (bus.dly[i*W +: W]),
      .p     (bus.p[i]),
      .l     (bus.l[i])
    );
  end

  assign bus.any = |bus.l;

endmodule

// File: doc/dly_bank.md
Name: dly_bank

Overview:
- Parametrised multi-channel delay unit; successor to the fixed-length single-purpose delay primitives.
- Each channel has a runtime-programmable tick count sampled at trigger, plus a one-cycle expiry pulse and a busy level.
- Adds behaviour the fixed primitives lack: selectable retrigger policy, synchronous cancel and auto-repeat (periodic) mode.
- Used wherever timing chains need delays selected at runtime or many parallel delays; clk is the 50 MHz system clock (20 ns/tick).

Parameters:
NCH, 4, number of independent channels
W, 8, counter/delay width in bits; max delay 2^W-1 ticks
RETRIG, 1, 1 = trigger while busy restarts the count; 0 = trigger while busy is ignored (except in the expiry cycle)

Ports:
clk  in  1  system clock, 20 ns period
reset  in  1  asynchronous, active-high reset
in  in  NCH  per-channel trigger, sampled on rising clk
clr  in  NCH  per-channel synchronous cancel
rep  in  NCH  per-channel auto-repeat select, sampled with trigger
dly  in  NCH*W  per-channel delay in ticks, channel i at bits [i*W +: W], sampled with trigger
p  out  NCH  per-channel expiry pulse, one cycle
l  out  NCH  per-channel busy level
any  out  1  OR of all l bits

Behaviour:
- Per-channel state: counter r[W], latched target t[W], latched repeat flag m, busy flag l. Channels are fully independent.
- Reset (async): r=0, t=0, m=0, l=0. Hence p=0 and any=0 immediately; no pulse on reset release.
- Trigger acceptance: accepted when in[i]=1 & clr[i]=0 & (l[i]=0 | p[i]=1 | RETRIG=1).
- On accept: r<=1, t<=(dly_i==0 ? 1 : dly_i), m<=rep[i], l<=1.
- Counting: while l=1 and no accept/clr, r<=r+1.
- Expiry: p[i] = l[i] & (r==t) & ~clr[i], combinational from state.
- Latency: in high in cycle c gives p high in cycle c+N, where N is the effective target. l is high from c+1 through c+N inclusive.
- On expiry without accept: m=0 gives r<=0, l<=0. m=1 gives r<=1, l stays 1, t and m kept, so p repeats every N cycles.
- Priority, highest first: clr > accept > expiry reload/stop > count.
- clr: r<=0, l<=0, m<=0 next edge; p suppressed in the clr cycle; a simultaneous in is discarded.
- Trigger during expiry cycle: p still pulses in that cycle; new count starts (r=1), l stays 1. This holds for either RETRIG value.
- RETRIG=0 with in while busy and not expiring: no effect on r, t, m.
- dly/rep are only sampled at accept; changes mid-count do not affect a running channel.
- Wrap-around: r never exceeds t, so the counter never wraps; t=2^W-1 is legal.
- Steady-high in with RETRIG=1: channel restarts every cycle, never expires (p=0) unless N=1. With N=1, p pulses every cycle.
- any = |l, combinational.

Decomposition:
- Shared package dly_pkg:
  - constant TICK_NS=20.
  - function ns_to_ticks(ns) = max(1, floor(ns/TICK_NS)), e.g. 45->2, 115->5, 250->12, 335->16.
  - W sizing helper clog2.
- One sub-module: dly_chan (single channel: r, t, m, l, p logic), instantiated NCH times by generate; top holds only slicing and the any reduction.

Test Plan:
- Basic: ch0 dly=5, rep=0, 1-cycle in at cycle 10 -> l0=1 cycles 11-15; p0=1 only at cycle 15; l0=0 at 16; other channels idle.
- Retrigger (RETRIG=1): dly=10, in at cycles 0 and 4 -> single p at cycle 14, l continuous 1-14. With RETRIG=0, same stimulus -> p at cycle 10, second in ignored.
- Repeat + cancel: ch1 dly=3, rep=1, in at 0 -> p1 at 3, 6, 9; clr at 11 -> l1=0 from 12, no p at 12. clr at cycle 12 (an expiry cycle) -> p1 suppressed in cycle 12.
- Edge values: dly=0 -> p at cycle 1 (treated as 1). dly=255 (W=8) -> p exactly at cycle 255, then l=0, no wrap pulse. in during expiry cycle with RETRIG=0 -> p pulses and a new count of N begins.
- Async reset mid-count: ch2 dly=20, in at 0, reset asserted at cycle 7 between edges -> l2, p2, any fall immediately. After release, no p ever appears without a new trigger.
- Parallel: all 4 channels triggered same cycle with dly=2,4,6,8 -> p at 2,4,6,8 respectively; any=1 cycles 1-8, 0 at 9.
